// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Push-button controlled, glitch-free BUFGCE CE sequencer with
//            quiesce handshake and post-enable settle window.
// Revision : 1.0
// ============================================================================
module clk_gate_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACK_TIMEOUT     = 255,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    input  logic stop_ack,
    output logic ce,
    output logic stop_req,
    output logic gated_ready,
    output logic timeout_flag,
    output logic key_press
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DW_W = (AT_W > ST_W) ? AT_W : ST_W;

    localparam logic [DB_W-1:0] c_db_last  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0] c_ack_last = DW_W'(ACK_TIMEOUT - 1);
    localparam logic [DW_W-1:0] c_set_last = DW_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_OFF    = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    logic            r_s1;
    logic            r_s2;
    logic            r_stable;
    logic            r_stable_d;
    logic            r_armed;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_key_press;

    // Until a debounced release is seen after reset, the debouncer only looks
    // for a sustained low, so a key held through reset is never accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_stable    <= 1'b0;
            r_stable_d  <= 1'b0;
            r_armed     <= 1'b0;
            r_db_cnt    <= '0;
            r_key_press <= 1'b0;
        end else begin
            r_s1        <= key_in;
            r_s2        <= r_s1;
            r_stable_d  <= r_stable;
            r_key_press <= r_stable & ~r_stable_d;
            if (!r_armed) begin
                if (!r_s1 && !r_s2) begin
                    if (r_db_cnt == c_db_last) begin
                        r_armed  <= 1'b1;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end else if (r_s2 != r_stable) begin
                if (r_db_cnt == c_db_last) begin
                    r_stable <= r_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    state_t          r_state;
    state_t          w_state;
    logic [DW_W-1:0] r_dwell;
    logic [DW_W-1:0] w_dwell;
    logic            r_ce;
    logic            r_stop_req;
    logic            r_gated_ready;
    logic            r_timeout;
    logic            w_timeout;

    always_comb begin
        w_state   = r_state;
        w_dwell   = r_dwell;
        w_timeout = r_timeout;
        case (r_state)
            S_RUN: begin
                if (r_key_press) begin
                    w_state   = S_DRAIN;
                    w_dwell   = '0;
                    w_timeout = 1'b0;
                end
            end
            S_DRAIN: begin
                if (stop_ack) begin
                    w_state = S_OFF;
                end else if (r_dwell == c_ack_last) begin
                    w_state   = S_OFF;
                    w_timeout = 1'b1;
                end else begin
                    w_dwell = r_dwell + 1'b1;
                end
            end
            S_OFF: begin
                if (r_key_press) begin
                    w_state = S_SETTLE;
                    w_dwell = '0;
                end
            end
            S_SETTLE: begin
                if (r_dwell == c_set_last) begin
                    w_state = S_RUN;
                end else begin
                    w_dwell = r_dwell + 1'b1;
                end
            end
            default: w_state = S_RUN;
        endcase
    end

    // Outputs are decoded from the next state so each is a plain flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_dwell       <= '0;
            r_ce          <= 1'b1;
            r_stop_req    <= 1'b0;
            r_gated_ready <= 1'b1;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_dwell       <= w_dwell;
            r_ce          <= (w_state != S_OFF);
            r_stop_req    <= (w_state == S_DRAIN);
            r_gated_ready <= (w_state == S_RUN);
            r_timeout     <= w_timeout;
        end
    end

    assign ce           = r_ce;
    assign stop_req     = r_stop_req;
    assign gated_ready  = r_gated_ready;
    assign timeout_flag = r_timeout;
    assign key_press    = r_key_press;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Brief    : Scoreboard bench for clk_gate_ctrl (DEBOUNCE=4, ACK=8, SETTLE=3).
// Revision : 1.0
// ============================================================================
module tb_clk_gate_ctrl;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic key_in   = 1'b0;
    logic stop_ack = 1'b0;
    wire  ce;
    wire  stop_req;
    wire  gated_ready;
    wire  timeout_flag;
    wire  key_press;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .ACK_TIMEOUT     (8),
        .SETTLE_CYCLES   (3)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .stop_ack     (stop_ack),
        .ce           (ce),
        .stop_req     (stop_req),
        .gated_ready  (gated_ready),
        .timeout_flag (timeout_flag),
        .key_press    (key_press)
    );

    // Vector order: {ce, stop_req, gated_ready, timeout_flag, key_press}
    localparam logic [4:0] c_RUN = 5'b10100;
    localparam logic [4:0] c_DRN = 5'b11000;
    localparam logic [4:0] c_OFF = 5'b00000;
    localparam logic [4:0] c_SET = 5'b10000;
    localparam logic [4:0] c_TF  = 5'b00010;
    localparam logic [4:0] c_KP  = 5'b00001;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (ce,stop_req,gated_ready,timeout_flag,key_press) t=%0t",
                      tag, obs, exp, $time);
    endtask

    task automatic tick(input logic ki, input logic ack, input logic [4:0] exp, input string tag);
        exp_t e;
        key_in   = ki;
        stop_ack = ack;
        e.tag    = tag;
        e.exp    = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(e.tag, {ce, stop_req, gated_ready, timeout_flag, key_press}, e.exp);
    endtask

    task automatic ticks(input int n, input logic ki, input logic ack, input logic [4:0] exp, input string tag);
        for (int i = 0; i < n; i++) tick(ki, ack, exp, tag);
    endtask

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        ticks(3, 1'b0, 1'b0, c_RUN, "reset");
        rst_n = 1'b1;
        ticks(50, 1'b0, 1'b0, c_RUN, "idle");

        // Bouncy key: never stable for 4 samples
        ticks(3, 1'b1, 1'b0, c_RUN, "bounce");
        ticks(2, 1'b0, 1'b0, c_RUN, "bounce");
        ticks(2, 1'b1, 1'b0, c_RUN, "bounce");
        ticks(8, 1'b0, 1'b1, c_RUN, "ack_in_run");

        // Clean held press, ack on the 3rd DRAIN cycle
        ticks(6, 1'b1, 1'b0, c_RUN, "pressA");
        tick(1'b1, 1'b0, c_RUN | c_KP, "pressA_kp");
        ticks(3, 1'b1, 1'b0, c_DRN, "drainA");
        tick(1'b1, 1'b1, c_OFF, "ackA");
        ticks(8, 1'b0, 1'b1, c_OFF, "off_ack_ignored");

        // Restart from OFF: ce first, gated_ready 3 edges later
        ticks(4, 1'b1, 1'b0, c_OFF, "pressB");
        ticks(2, 1'b0, 1'b0, c_OFF, "pressB");
        tick(1'b0, 1'b0, c_OFF | c_KP, "pressB_kp");
        ticks(3, 1'b0, 1'b0, c_SET, "settleB");
        ticks(4, 1'b0, 1'b0, c_RUN, "runB");

        // Timeout path; a second press lands at the end of DRAIN and is dropped
        ticks(4, 1'b1, 1'b0, c_RUN, "pressC");
        ticks(2, 1'b0, 1'b0, c_RUN, "pressC");
        tick(1'b0, 1'b0, c_RUN | c_KP, "pressC_kp");
        tick(1'b0, 1'b0, c_DRN, "drainC");
        ticks(6, 1'b1, 1'b0, c_DRN, "drainC");
        tick(1'b1, 1'b0, c_DRN | c_KP, "drainC_kp");
        tick(1'b1, 1'b0, c_OFF | c_TF, "timeoutC");
        ticks(7, 1'b1, 1'b0, c_OFF | c_TF, "press_not_queued");
        ticks(8, 1'b0, 1'b0, c_OFF | c_TF, "releaseC");

        // Restart keeps timeout_flag
        ticks(4, 1'b1, 1'b0, c_OFF | c_TF, "pressD");
        ticks(2, 1'b0, 1'b0, c_OFF | c_TF, "pressD");
        tick(1'b0, 1'b0, c_OFF | c_TF | c_KP, "pressD_kp");
        ticks(3, 1'b0, 1'b0, c_SET | c_TF, "settleD");
        ticks(4, 1'b0, 1'b0, c_RUN | c_TF, "tf_held_run");

        // Next stop clears timeout_flag; ack in the first DRAIN cycle
        ticks(4, 1'b1, 1'b0, c_RUN | c_TF, "pressE");
        ticks(2, 1'b0, 1'b0, c_RUN | c_TF, "pressE");
        tick(1'b0, 1'b0, c_RUN | c_TF | c_KP, "pressE_kp");
        tick(1'b0, 1'b0, c_DRN, "tf_clear");
        tick(1'b0, 1'b1, c_OFF, "ack_first");
        ticks(4, 1'b0, 1'b0, c_OFF, "offE");

        // Back to RUN
        ticks(4, 1'b1, 1'b0, c_OFF, "pressG");
        ticks(2, 1'b0, 1'b0, c_OFF, "pressG");
        tick(1'b0, 1'b0, c_OFF | c_KP, "pressG_kp");
        ticks(3, 1'b0, 1'b0, c_SET, "settleG");
        ticks(4, 1'b0, 1'b0, c_RUN, "runG");

        // Reset while in DRAIN with the key held
        ticks(6, 1'b1, 1'b0, c_RUN, "pressF");
        tick(1'b1, 1'b0, c_RUN | c_KP, "pressF_kp");
        ticks(2, 1'b1, 1'b0, c_DRN, "drainF");
        rst_n = 1'b0;
        tick(1'b1, 1'b0, c_RUN, "rst_in_drain");
        rst_n = 1'b1;
        ticks(20, 1'b1, 1'b0, c_RUN, "held_thru_reset");
        ticks(6, 1'b0, 1'b0, c_RUN, "release");
        ticks(6, 1'b1, 1'b0, c_RUN, "repress");
        tick(1'b1, 1'b0, c_RUN | c_KP, "repress_kp");
        tick(1'b1, 1'b0, c_DRN, "repress_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
Drives the CE pin of a BUFGCE from a raw push-button, so an operator can stop and restart a gated clock domain without glitches. A debounced press first requests quiesce from the gated logic and waits for acknowledge or timeout. It then drops CE. The next press re-enables CE and holds off gated_ready until a settle window has elapsed. Runs on the free-running clock that feeds the BUFGCE I input.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a key level change (20 ms at 50 MHz); must be >= 2
ACK_TIMEOUT, 255, maximum cycles spent in DRAIN waiting for stop_ack; must be >= 1
SETTLE_CYCLES, 4, cycles CE is high before gated_ready asserts; must be >= 1

Ports:
clk  in  1  free-running clock, same net as BUFGCE I
rst_n  in  1  reset, synchronous, active-low
key_in  in  1  raw button, asynchronous, bouncy, high = pressed
stop_ack  in  1  quiesce acknowledge from gated domain, already synchronised to clk
ce  out  1  to BUFGCE CE, registered
stop_req  out  1  quiesce request to gated domain, registered
gated_ready  out  1  gated clock running and settled, registered
timeout_flag  out  1  sticky: last stop completed by timeout, not by ack
key_press  out  1  one-cycle pulse per accepted press (debug/LED)

Behaviour:
- Reset state: sync flops 0, stable=0, debounce count 0, FSM RUN, ce=1, stop_req=0, gated_ready=1, timeout_flag=0, key_press=0. The clock runs out of reset.
- Input synchroniser: two flops s1<-key_in, s2<-s1.
- Debounce:
  - Counter increments each cycle while s2 != stable.
  - The counter clears to 0 in any cycle where s2 == stable (a bounce restarts the count).
  - When s2 != stable and count == DEBOUNCE_CYCLES-1: stable<=s2 and count<=0.
- key_press: registered, equals 1 for exactly one cycle after stable goes 0->1. Releases (1->0) produce no pulse.
- Press latency: a clean key_in rise first sampled at edge e0 gives key_press high after edge e0+DEBOUNCE_CYCLES+2.
- FSM, transitions on clk edges; outputs are registered alongside the state:
  - RUN: ce=1, gated_ready=1, stop_req=0. key_press -> DRAIN; the dwell counter clears and timeout_flag clears.
  - DRAIN: ce=1, gated_ready=0, stop_req=1.
    - stop_ack sampled 1 -> OFF.
    - Otherwise, with dwell == ACK_TIMEOUT-1 -> OFF and timeout_flag<=1.
    - Otherwise dwell increments.
    - A stop_ack in the first DRAIN cycle is honoured, so minimum DRAIN dwell is 1 cycle.
  - OFF: ce=0, stop_req=0, gated_ready=0. key_press -> SETTLE; dwell clears.
  - SETTLE: ce=1, stop_req=0, gated_ready=0. dwell == SETTLE_CYCLES-1 -> RUN; otherwise dwell increments.
- key_press in DRAIN or SETTLE is ignored and discarded, not queued.
- stop_ack outside DRAIN is ignored.
- ce changes only on clk edges, as a single flop output with no combinational path. The BUFGCE's own enable latch makes the gating glitch-free.
- timeout_flag holds its value across OFF, SETTLE and RUN. It clears only on reset or on the RUN->DRAIN transition.
- Reset mid-operation (any state): the next edge forces the reset values above, with ce=1 immediately. The debounce state clears, so a key held through reset must be released and re-pressed before it is accepted.
- Counter widths: sized by $clog2 of each parameter and must not wrap. The debounce counter saturates by construction through the compare-and-clear.

Test Plan:
Use DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8, SETTLE_CYCLES=3 for all scenarios.
1. Hold rst_n=0 for 3 cycles with key_in=0, then release -> ce=1, gated_ready=1, stop_req=0, timeout_flag=0, key_press never pulses for 50 cycles.
2. From RUN, key_in high for 3 cycles, low 2, high 2, low -> no key_press, FSM stays RUN. Then a clean key_in high first sampled at e0 -> key_press high only after edge e0+6, stop_req=1 and gated_ready=0 one edge later.
3. In DRAIN, assert stop_ack on the 3rd DRAIN cycle -> ce=0 and stop_req=0 on the next edge, timeout_flag=0.
4. In DRAIN with stop_ack held 0 -> exactly 8 cycles of stop_req=1, then ce=0 and timeout_flag=1. timeout_flag remains 1 through the restart and clears on the next stop press.
5. In OFF, press -> ce=1 on the edge after the FSM accepts the press, gated_ready=1 exactly 3 edges after ce rises. A second press delivered during SETTLE is ignored and the FSM ends in RUN.
6. In DRAIN, pulse rst_n=0 for 1 cycle -> next edge gives ce=1, stop_req=0, gated_ready=1, FSM RUN. A key still held high gives no key_press until it is released and pressed again.
